assumer4_controller: RTL

- Round-robin sequencer that shares one assumer4 datapath among NUM_REQ requesters.
- Grants one requester, drives the datapath start/set-ready controls, and waits for the datapath's begin/ready responses.
- Holds the datapath busy for a fixed run length and reports completion or timeout to the granted requester.
- Sits between the requester agents and the assumer4 datapath instance.

---
 rtl/assumer4_controller.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/assumer4_controller.sv
// assumer4_controller: round-robin sequencer sharing one assumer4 datapath
// among NUM_REQ requesters. It grants one requester, raises startAR4 until
// the datapath answers with beginAR4, keeps the datapath busy for RUN_CYCLES,
// raises setRAR4 until readyAR4, then pulses done. A missing response within
// TIMEOUT cycles pulses err instead.
//
// Handshake: startAR4 and setRAR4 behave as "valid" and stay high until the
// datapath answers. beginAR4 and readyAR4 behave as "ready". One is taken on
// the rising edge where its control is high and the response is also high.
// beginAR4 is looked at only in START and readyAR4 only in SETR.
module assumer4_controller #(
    parameter int NUM_REQ    = 4,
    parameter int RUN_CYCLES = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               done,
    output logic               err,
    output logic               busy,
    output logic               startAR4,
    output logic               setRAR4,
    input  logic               beginAR4,
    input  logic               readyAR4,
    output logic [2:0]         dbg_state_o,
    output logic [2:0]         dbg_ptr_o
);

    localparam int CNT_MAX = (RUN_CYCLES > TIMEOUT) ? RUN_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_SETR  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   run_q, run_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               done_q, err_q, busy_q, start_q, setr_q;

    logic               sel_found;
    logic [PTR_W-1:0]   sel_idx;
    logic [31:0]        cand;

    // Next index after the granted one, wrapping at NUM_REQ.
    logic [PTR_W-1:0]   idx_next;
    assign idx_next = (idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    // Round-robin pick: first asserted request searching from ptr upwards.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr_q) + 32'(i)) % 32'(NUM_REQ);
            if (!sel_found && req[cand[PTR_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Next-state logic: transitions, counters, grant and pointer updates.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        run_d   = run_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    gnt_d          = '0;
                    gnt_d[sel_idx] = 1'b1;
                    idx_d          = sel_idx;
                    tmo_d          = CNT_W'(TIMEOUT);
                    state_d        = S_START;
                end
            end
            S_START: begin
                // The response sampled on the last allowed cycle still wins.
                if (beginAR4) begin
                    run_d   = CNT_W'(RUN_CYCLES);
                    state_d = S_RUN;
                end else if (tmo_q <= CNT_W'(1)) begin
                    tmo_d   = '0;
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            S_RUN: begin
                if (run_q <= CNT_W'(1)) begin
                    run_d   = '0;
                    tmo_d   = CNT_W'(TIMEOUT);
                    state_d = S_SETR;
                end else begin
                    run_d = run_q - 1'b1;
                end
            end
            S_SETR: begin
                if (readyAR4) begin
                    state_d = S_DONE;
                end else if (tmo_q <= CNT_W'(1)) begin
                    tmo_d   = '0;
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            S_DONE, S_ERR: begin
                ptr_d   = idx_next;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            run_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            setr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            run_q   <= run_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
            busy_q  <= (state_d != S_IDLE);
            start_q <= (state_d == S_START);
            setr_q  <= (state_d == S_SETR);
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign startAR4    = start_q;
    assign setRAR4     = setr_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = 3'(ptr_q);

endmodule
